// File: rtl/dcache_flush_engine.sv
// Data-cache write-back/flush sequencer: drains the MSHR, walks every set/way,
// stores valid+dirty lines to memory, cleans (optionally invalidates) them, then halts the pipeline.
module dcache_flush_engine #(
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2,
  parameter int INVALIDATE = 0,
  localparam int SET_W     = $clog2(NUM_SETS),
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int TAG_W      = 64 - SET_W - 3,
  localparam int CNT_W     = SET_W + WAY_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_req,
  input  logic             mshr_empty,
  output logic             rd_en,
  output logic [SET_W-1:0] rd_set,
  output logic [WAY_W-1:0] rd_way,
  input  logic             rd_valid,
  input  logic             rd_dirty,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [63:0]      rd_data,
  output logic             clr_en,
  output logic [SET_W-1:0] clr_set,
  output logic [WAY_W-1:0] clr_way,
  output logic [1:0]       proc2mem_command,
  output logic [63:0]      proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  input  logic [3:0]       mem2proc_response,
  output logic             busy,
  output logic             halt_pipeline,
  output logic [CNT_W-1:0] lines_written
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_DRAIN = 4'd1;
  localparam logic [3:0] S_READ  = 4'd2;
  localparam logic [3:0] S_CHECK = 4'd3;
  localparam logic [3:0] S_WRITE = 4'd4;
  localparam logic [3:0] S_CLEAN = 4'd5;
  localparam logic [3:0] S_NEXT  = 4'd6;
  localparam logic [3:0] S_FINAL = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [SET_W-1:0] set_cnt;
  logic [WAY_W-1:0] way_cnt;
  logic [TAG_W-1:0] tag_q;
  logic [63:0]      data_q;
  logic             way_last;
  logic             last_line;
  logic             store_accepted;

  assign way_last       = (way_cnt == WAY_W'(NUM_WAYS - 1));
  assign last_line      = way_last && (set_cnt == SET_W'(NUM_SETS - 1));
  assign store_accepted = (state == S_WRITE) && (mem2proc_response != 4'd0);

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (flush_req) state_nxt = S_DRAIN;
      S_DRAIN: if (mshr_empty) state_nxt = S_READ;
      S_READ:  state_nxt = S_CHECK;
      S_CHECK: begin
        if (rd_valid && rd_dirty)                state_nxt = S_WRITE;
        else if ((INVALIDATE != 0) && rd_valid)  state_nxt = S_CLEAN;
        else                                     state_nxt = S_NEXT;
      end
      S_WRITE: if (store_accepted) state_nxt = S_CLEAN;
      S_CLEAN: state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_line ? S_FINAL : S_READ;
      S_FINAL: if (mshr_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      set_cnt       <= '0;
      way_cnt       <= '0;
      lines_written <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && flush_req) begin
        set_cnt <= '0;
        way_cnt <= '0;
      end else if (state == S_NEXT && !last_line) begin
        if (way_last) begin
          way_cnt <= '0;
          set_cnt <= set_cnt + SET_W'(1);
        end else begin
          way_cnt <= way_cnt + WAY_W'(1);
        end
      end
      if (store_accepted) lines_written <= lines_written + CNT_W'(1);
    end
  end

  // NOTE: line capture registers carry no reset; they are only observed while in WRITE.
  always_ff @(posedge clock) begin
    if (state == S_CHECK) begin
      tag_q  <= rd_tag;
      data_q <= rd_data;
    end
  end

  assign rd_en   = (state == S_READ);
  assign rd_set  = set_cnt;
  assign rd_way  = way_cnt;
  assign clr_en  = (state == S_CLEAN);
  assign clr_set = set_cnt;
  assign clr_way = way_cnt;

  assign proc2mem_command = (state == S_WRITE) ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = (state == S_WRITE) ? {tag_q, set_cnt, 3'b000} : 64'd0;
  assign proc2mem_data    = (state == S_WRITE) ? data_q : 64'd0;

  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign halt_pipeline = (state == S_DONE);

endmodule
